mux_n_in_pipe: RTL
==================

Name: mux_n_in_pipe

Overview:
- Parametrised, registered N-input data multiplexer. Successor to the 3-input combinational datapath mux.
- Used for operand-forwarding and writeback-source selection in the pipelined datapath. Sits at a stage boundary and replaces the mux plus pipeline register pair.
- Adds a 1-cycle registered output, stall, flush and per-channel valid bits.
- Adds an optional round-robin mode so several producers can share one pipeline slot. A transfer counter is provided for debug.

Parameters:
- DB, 32: data width of each channel and of Salida.
- N, 4: number of input channels, 2..16.
- SW, 2: width of Sel and Canal. Must be >= clog2(N).
- RR_MODE, 0: 0 = explicit selection by Sel; 1 = round-robin among valid channels, Sel ignored.

Ports:
- Clk  in  1  system clock. All state updates on the rising edge.
- Reset  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- Datos  in  N*DB  packed inputs. Channel i is Datos[i*DB +: DB].
- Validos  in  N  per-channel valid bits.
- Sel  in  SW  channel select, used only when RR_MODE=0.
- Enable  in  1  1 = advance stage; 0 = stall (hold all state).
- Flush  in  1  1 = insert a bubble.
- Salida  out  DB  registered selected data.
- Salida_Valida  out  1  registered valid bit for Salida.
- Canal  out  SW  registered index of the channel captured into Salida.
- Sel_Fuera  out  1  registered flag: the captured Sel was >= N (RR_MODE=0 only; tied 0 when RR_MODE=1).
- Grant  out  N  combinational one-hot: channel consumed at this edge.
- Conteo  out  16  count of valid transfers captured.

Behaviour:
- Priority at each rising edge: Reset low > Flush > Enable=0 > normal capture.
- Reset (Reset=0 at the edge):
  - Salida=0, Salida_Valida=0, Canal=0, Sel_Fuera=0, Conteo=0.
  - Round-robin pointer P=0.
  - Reset asserted mid-stream discards any pending capture.
- Flush=1 (Reset=1):
  - Salida=0, Salida_Valida=0, Canal=0, Sel_Fuera=0.
  - P and Conteo are unchanged; Grant=0.
  - Flush overrides Enable=0: a bubble is inserted even during a stall.
- Stall (Enable=0, Flush=0): all registers, including P and Conteo, hold; Grant=0.
- Latency: exactly 1 cycle from inputs sampled at edge k to Salida and Salida_Valida valid after edge k.
- RR_MODE=0, normal capture:
  - idx = Sel if Sel < N, else N-1. Out-of-range selects saturate to the last channel, preserving legacy default-to-last behaviour.
  - Salida <= Datos[idx], Canal <= idx, Salida_Valida <= Validos[idx], Sel_Fuera <= (Sel >= N).
  - Grant = onehot(idx) when Validos[idx]=1, else 0.
  - Data is captured even when Validos[idx]=0; consumers must qualify it with Salida_Valida.
- RR_MODE=1, normal capture:
  - Search channels P, P+1, ..., N-1, 0, ..., P-1 and take the first g with Validos[g]=1.
  - If found: Salida <= Datos[g], Salida_Valida <= 1, Canal <= g, P <= (g+1) mod N, Grant = onehot(g).
  - If none found: Salida and Canal hold, Salida_Valida <= 0, P unchanged, Grant=0.
  - Wrap: g = N-1 sets P to 0.
  - When N is not a power of two, P never holds a value >= N.
- Grant is purely combinational from Reset, Flush, Enable, Validos, Sel and P. It is 0 whenever Reset=0, Flush=1 or Enable=0.
- Conteo increments by 1 on every edge where Grant != 0. It wraps from 65535 to 0.
- No latches. Every output has a defined value on every cycle after the first reset edge.

Test Plan (N=4, DB=32 unless noted):
- Reset: hold Reset=0 for 2 edges with random inputs -> Salida=0, Salida_Valida=0, Canal=0, Conteo=0, Grant=0.
- RR_MODE=0, Enable=1:
  - Datos = {0x44,0x33,0x22,0x11}, Validos=4'b1111, Sel=2 -> one edge later Salida=0x33, Canal=2, Salida_Valida=1, Conteo=1.
  - Repeat with N=3 and Sel=3 -> Salida = channel 2 data, Sel_Fuera=1.
- Stall and flush, RR_MODE=0:
  - Capture 0x22, then Enable=0 for 3 edges while changing Sel/Datos -> Salida stays 0x22, Conteo constant, Grant=0.
  - Then Flush=1 with Enable=0 -> Salida_Valida=0, Salida=0.
- RR_MODE=1 fairness: Validos=4'b1011, Enable=1 for 6 edges -> Canal sequence 0,1,3,0,1,3; Conteo=6.
- RR_MODE=1 empty and wrap:
  - Validos=0 for 2 edges -> Salida_Valida=0, Salida holds, P unchanged.
  - Then Validos=4'b1000 -> Canal=3, next grant search starts at 0.
- Reset mid-operation: in RR mode with P=2, drive Reset=0 for 1 edge, then Validos=4'b1111 -> first grant is channel 0. Separately, preload Conteo near 65535 and run 2 transfers -> Conteo wraps to 0 then 1.

Source files
------------

// File: rtl/mux_n_in_pipe.sv
// Registered N-input select stage: explicit or round-robin channel choice,
// with stall, flush, per-channel valid and a transfer counter.
module mux_n_in_pipe #(
    parameter int DB      = 32,
    parameter int N       = 4,
    parameter int SW      = 2,
    parameter int RR_MODE = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N*DB-1:0] Datos,
    input  logic [N-1:0]    Validos,
    input  logic [SW-1:0]   Sel,
    input  logic            Enable,
    input  logic            Flush,
    output logic [DB-1:0]   Salida,
    output logic            Salida_Valida,
    output logic [SW-1:0]   Canal,
    output logic            Sel_Fuera,
    output logic [N-1:0]    Grant,
    output logic [15:0]     Conteo
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [DB-1:0] salida_q, salida_d;
    logic          valida_q, valida_d;
    logic [SW-1:0] canal_q, canal_d;
    logic          fuera_q, fuera_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [15:0]   conteo_q, conteo_d;

    logic          advance;
    logic          sel_oor;
    logic [SW-1:0] fix_idx;
    logic          rr_hit;
    logic [SW-1:0] rr_idx;
    int            cand;
    logic [SW-1:0] pick_idx;
    logic          pick_vld;
    logic [DB-1:0] pick_dat;
    logic [N-1:0]  grant;

    // The stage moves only when out of reset, not flushed and not stalled
    always_comb begin
        advance = Reset & ~Flush & Enable;
    end

    // Explicit select: out-of-range selects fall back to the last channel
    always_comb begin
        sel_oor = (32'(Sel) >= 32'(N));
        fix_idx = sel_oor ? LAST : Sel;
    end

    // Round-robin search starting at the pointer, first valid channel wins
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!rr_hit && Validos[cand]) begin
                rr_hit = 1'b1;
                rr_idx = SW'(cand);
            end
        end
    end

    // Channel chosen this cycle, its valid bit, data and one-hot grant
    always_comb begin
        pick_idx = (RR_MODE != 0) ? rr_idx : fix_idx;
        pick_vld = (RR_MODE != 0) ? rr_hit : Validos[fix_idx];
        pick_dat = Datos[int'(pick_idx)*DB +: DB];
        grant    = '0;
        if (advance && pick_vld) begin
            grant = N'(1) << pick_idx;
        end
    end

    // Next-state: flush beats stall, stall holds, otherwise capture
    always_comb begin
        salida_d = salida_q;
        valida_d = valida_q;
        canal_d  = canal_q;
        fuera_d  = fuera_q;
        ptr_d    = ptr_q;
        conteo_d = conteo_q;
        priority case (1'b1)
            Flush: begin
                salida_d = '0;
                valida_d = 1'b0;
                canal_d  = '0;
                fuera_d  = 1'b0;
            end
            !Enable: begin
            end
            default: begin
                if (RR_MODE != 0) begin
                    valida_d = rr_hit;
                    if (rr_hit) begin
                        salida_d = pick_dat;
                        canal_d  = pick_idx;
                        ptr_d    = (pick_idx == LAST) ? '0
                                 : pick_idx + 1'b1;
                    end
                end else begin
                    salida_d = pick_dat;
                    canal_d  = pick_idx;
                    valida_d = pick_vld;
                    fuera_d  = sel_oor;
                end
                if (|grant) begin
                    conteo_d = conteo_q + 16'd1;
                end
            end
        endcase
    end

    // Stage registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            salida_q <= '0;
            valida_q <= 1'b0;
            canal_q  <= '0;
            fuera_q  <= 1'b0;
            ptr_q    <= '0;
            conteo_q <= '0;
        end else begin
            salida_q <= salida_d;
            valida_q <= valida_d;
            canal_q  <= canal_d;
            fuera_q  <= fuera_d;
            ptr_q    <= ptr_d;
            conteo_q <= conteo_d;
        end
    end

    assign Salida        = salida_q;
    assign Salida_Valida = valida_q;
    assign Canal         = canal_q;
    assign Sel_Fuera     = fuera_q;
    assign Grant         = grant;
    assign Conteo        = conteo_q;

endmodule
